butterfly_r2_pipe: RTL and testbench
====================================

BUTTERFLY_R2_PIPE -- requirements
Module: butterfly_r2_pipe

Interface
REQ-001 Parameter DW, default 16, two's-complement data width of each real/imag component.
REQ-002 Parameter TW, default 16, twiddle component width, signed Q1.(TW-1).
REQ-003 clk  in  1  clock; all state on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 in_valid  in  1  input beat valid.
REQ-006 in_ready  out  1  block accepts beat this cycle.
REQ-007 ar, ai, br, bi  in  DW each  operands A and B, real/imag.
REQ-008 wr, wi  in  TW each  twiddle W, real/imag.
REQ-009 mode_dif  in  1  0 = DIT, 1 = DIF; sampled with beat.
REQ-010 inv  in  1  1 = use conj(W) (inverse transform); sampled with beat.
REQ-011 scale  in  1  1 = divide both outputs by 2; sampled with beat.
REQ-012 out_valid  out  1  output beat valid.
REQ-013 out_ready  in  1  downstream accepts output.
REQ-014 xr, xi, yr, yi  out  DW each  results X and Y.
REQ-015 sat  out  1  current output beat saturated in any component.
REQ-016 ovf_sticky  out  1  latched saturation flag.
REQ-017 clr_ovf  in  1  clears ovf_sticky.

Function
REQ-018 Beat transfers on in_valid && in_ready; output transfers on out_valid && out_ready.
REQ-019 Global enable en = !out_valid || out_ready; in_ready = en; all stages advance only when en=1, otherwise all stage registers, valids and outputs hold.
REQ-020 Four-stage pipeline: latency exactly 4 cycles from accepted beat to out_valid with no stall; throughput 1 beat/cycle; order preserved.
REQ-021 Stage 1: register operands, W, mode_dif, inv, scale, valid.
REQ-022 Stage 2: M = B (DIT) or A-B (DIF, DW+1 bits); S = A+B (DW+1 bits); full-precision products Mr*Wr, Mi*Wi, Mr*Wi, Mi*Wr.
REQ-023 Stage 3: s = +1 (inv=0) or -1 (inv=1); Zr = Mr*Wr - s*Mi*Wi; Zi = s*Mr*Wi + Mi*Wr; conj(W) is applied by sign of the product term, never by negating wi (wi = -2^(TW-1) is legal).
REQ-024 Stage 3 rounding: Z = (sum + 2^(TW-2)) >>> (TW-1), arithmetic shift, round-half-up, kept at DW+2 bits.
REQ-025 Stage 4 DIT: X = A+Z, Y = A-Z; DIF: X = S, Y = Z; intermediate DW+3 bits, no wrap.
REQ-026 Stage 4 scale=1: each component v becomes (v+1) >>> 1 before saturation.
REQ-027 Saturation: each component clamped to [-2^(DW-1), 2^(DW-1)-1]; sat = OR of the four clamp events, registered with the outputs.
REQ-028 ovf_sticky set on any output beat loaded into the output register with sat=1; cleared by clr_ovf; simultaneous set and clr: set wins.
REQ-029 Outputs and sat change only when en=1; with out_valid=0 outputs retain their last value.
REQ-030 Per-beat controls (mode_dif, inv, scale) travel with their beat; mixed modes back-to-back are legal.

Reset
REQ-031 rst=1 clears all stage valids, out_valid, xr, xi, yr, yi, sat, ovf_sticky to 0 on the next edge, overriding en and clr_ovf.
REQ-032 Reset mid-operation discards all in-flight beats; no beat accepted before reset emerges afterwards.
REQ-033 in_ready = 1 in the first cycle after reset release.

Verification (DW=16, TW=16, out_ready=1 unless stated)
REQ-034 Reset: assert rst with pipeline full -> next cycle out_valid=0, all outputs 0, ovf_sticky=0.
REQ-035 DIT fwd: A=(1000,0), B=(2000,0), W=(0,-32768) -> 4 cycles later X=(1000,-2000), Y=(1000,2000), sat=0.
REQ-036 DIT inv, same operands -> X=(1000,2000), Y=(1000,-2000).
REQ-037 Saturation: A=(32767,0), B=(32767,0), W=(16384,0), scale=0 -> X=(32767,0) sat=1, Y=(16383,0), ovf_sticky=1 until clr_ovf; with scale=1 -> X=(24576,0), Y=(8192,0), sat=0.
REQ-038 DIF: A=(300,100), B=(100,-100), W=(16384,0) -> X=(400,0), Y=(100,100).
REQ-039 Backpressure: 4 back-to-back beats, out_ready=0 for 3 cycles once out_valid rises -> in_ready=0 and outputs stable during stall, all 4 results delivered in order, none lost or duplicated.

Source files
------------

// File: rtl/butterfly_r2_pipe.sv
// butterfly_r2_pipe
// Four-stage pipelined radix-2 butterfly for complex fixed-point data.
// Per beat it computes either a DIT butterfly (X = A + B*W, Y = A - B*W) or a
// DIF butterfly (X = A + B, Y = (A - B)*W). The twiddle can be conjugated for
// inverse transforms, and both results can optionally be halved. Every result
// component saturates to the DW-bit range.
//
// Ports
//   clk, rst               clock; synchronous active-high reset
//   in_valid / in_ready    input handshake (in_ready is the global enable)
//   ar, ai, br, bi         operands A and B (signed DW bits)
//   wr, wi                 twiddle W (signed Q1.(TW-1))
//   mode_dif, inv, scale   per-beat controls that travel with the beat
//   out_valid / out_ready  output handshake
//   xr, xi, yr, yi         results X and Y (signed DW bits)
//   sat                    some component of the current output beat was clamped
//   ovf_sticky, clr_ovf    latched saturation flag and its clear
module butterfly_r2_pipe #(
    parameter int DW = 16,
    parameter int TW = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic signed [DW-1:0] ar, ai, br, bi,
    input  logic signed [TW-1:0] wr, wi,
    input  logic                 mode_dif, inv, scale,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic signed [DW-1:0] xr, xi, yr, yi,
    output logic                 sat,
    output logic                 ovf_sticky,
    input  logic                 clr_ovf
);
    localparam int MW = DW + 1;   // A+B, A-B
    localparam int PW = MW + TW;  // full-precision product
    localparam int SW = PW + 1;   // sum of two products
    localparam int ZW = DW + 2;   // rounded twiddle product
    localparam int OW = DW + 3;   // stage-4 intermediate before clamping

    localparam logic signed [SW-1:0] RND  = {{(SW-TW+1){1'b0}}, 1'b1, {(TW-2){1'b0}}};
    localparam logic signed [OW-1:0] ONE  = {{(OW-1){1'b0}}, 1'b1};
    localparam logic signed [OW-1:0] MAXV = {{(OW-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [OW-1:0] MINV = {{(OW-DW+1){1'b1}}, {(DW-1){1'b0}}};

    // A single enable stalls every stage at once whenever the output is full
    // and not being taken.
    logic en;
    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    // Stage 1: capture the beat as presented.
    logic                 s1_valid, s1_dif, s1_inv, s1_scale;
    logic signed [DW-1:0] s1_ar, s1_ai, s1_br, s1_bi;
    logic signed [TW-1:0] s1_wr, s1_wi;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
        end else if (en) begin
            s1_valid <= in_valid;
            s1_ar    <= ar;
            s1_ai    <= ai;
            s1_br    <= br;
            s1_bi    <= bi;
            s1_wr    <= wr;
            s1_wi    <= wi;
            s1_dif   <= mode_dif;
            s1_inv   <= inv;
            s1_scale <= scale;
        end
    end

    // Stage 2: choose the multiplicand (B for DIT, A-B for DIF) and form A+B.
    logic signed [MW-1:0] m_r, m_i, s_r, s_i;

    always_comb begin
        s_r = MW'(s1_ar) + MW'(s1_br);
        s_i = MW'(s1_ai) + MW'(s1_bi);
        if (s1_dif) begin
            m_r = MW'(s1_ar) - MW'(s1_br);
            m_i = MW'(s1_ai) - MW'(s1_bi);
        end else begin
            m_r = MW'(s1_br);
            m_i = MW'(s1_bi);
        end
    end

    logic                 s2_valid, s2_dif, s2_inv, s2_scale;
    logic signed [PW-1:0] s2_prr, s2_pii, s2_pri, s2_pir;
    logic signed [MW-1:0] s2_sr, s2_si;
    logic signed [DW-1:0] s2_ar, s2_ai;

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid <= 1'b0;
        end else if (en) begin
            s2_valid <= s1_valid;
            s2_prr   <= PW'(m_r) * PW'(s1_wr);
            s2_pii   <= PW'(m_i) * PW'(s1_wi);
            s2_pri   <= PW'(m_r) * PW'(s1_wi);
            s2_pir   <= PW'(m_i) * PW'(s1_wr);
            s2_sr    <= s_r;
            s2_si    <= s_i;
            s2_ar    <= s1_ar;
            s2_ai    <= s1_ai;
            s2_dif   <= s1_dif;
            s2_inv   <= s1_inv;
            s2_scale <= s1_scale;
        end
    end

    // Stage 3: conj(W) flips the sign of the wi product terms rather than
    // negating wi, because wi = -2^(TW-1) has no positive counterpart.
    logic signed [SW-1:0] zr_sum, zi_sum;

    always_comb begin
        if (s2_inv) begin
            zr_sum = SW'(s2_prr) + SW'(s2_pii);
            zi_sum = SW'(s2_pir) - SW'(s2_pri);
        end else begin
            zr_sum = SW'(s2_prr) - SW'(s2_pii);
            zi_sum = SW'(s2_pir) + SW'(s2_pri);
        end
    end

    logic                 s3_valid, s3_dif, s3_scale;
    logic signed [ZW-1:0] s3_zr, s3_zi;
    logic signed [MW-1:0] s3_sr, s3_si;
    logic signed [DW-1:0] s3_ar, s3_ai;

    // Round half up back to data scale; the result always fits in DW+2 bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            s3_valid <= 1'b0;
        end else if (en) begin
            s3_valid <= s2_valid;
            s3_zr    <= ZW'((zr_sum + RND) >>> (TW-1));
            s3_zi    <= ZW'((zi_sum + RND) >>> (TW-1));
            s3_sr    <= s2_sr;
            s3_si    <= s2_si;
            s3_ar    <= s2_ar;
            s3_ai    <= s2_ai;
            s3_dif   <= s2_dif;
            s3_scale <= s2_scale;
        end
    end

    // Stage 4: combine, optionally halve with rounding, then clamp.
    function automatic logic signed [OW-1:0] halve(input logic signed [OW-1:0] v,
                                                   input logic                 do_half);
        halve = do_half ? ((v + ONE) >>> 1) : v;
    endfunction

    // Returns {clamped, value}.
    function automatic logic [DW:0] clamp(input logic signed [OW-1:0] v);
        if (v > MAXV)
            clamp = {1'b1, MAXV[DW-1:0]};
        else if (v < MINV)
            clamp = {1'b1, MINV[DW-1:0]};
        else
            clamp = {1'b0, v[DW-1:0]};
    endfunction

    logic signed [OW-1:0] x_r_w, x_i_w, y_r_w, y_i_w;
    logic        [DW:0]   c_xr, c_xi, c_yr, c_yi;
    logic                 sat_c;

    always_comb begin
        if (s3_dif) begin
            x_r_w = OW'(s3_sr);
            x_i_w = OW'(s3_si);
            y_r_w = OW'(s3_zr);
            y_i_w = OW'(s3_zi);
        end else begin
            x_r_w = OW'(s3_ar) + OW'(s3_zr);
            x_i_w = OW'(s3_ai) + OW'(s3_zi);
            y_r_w = OW'(s3_ar) - OW'(s3_zr);
            y_i_w = OW'(s3_ai) - OW'(s3_zi);
        end
        c_xr  = clamp(halve(x_r_w, s3_scale));
        c_xi  = clamp(halve(x_i_w, s3_scale));
        c_yr  = clamp(halve(y_r_w, s3_scale));
        c_yi  = clamp(halve(y_i_w, s3_scale));
        sat_c = c_xr[DW] | c_xi[DW] | c_yr[DW] | c_yi[DW];
    end

    // Output register: data and sat load only with a valid beat, so they keep
    // their last value while out_valid is low. A saturating beat being loaded
    // takes priority over clr_ovf.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            xr         <= '0;
            xi         <= '0;
            yr         <= '0;
            yi         <= '0;
            sat        <= 1'b0;
            ovf_sticky <= 1'b0;
        end else begin
            if (en) begin
                out_valid <= s3_valid;
                if (s3_valid) begin
                    xr  <= c_xr[DW-1:0];
                    xi  <= c_xi[DW-1:0];
                    yr  <= c_yr[DW-1:0];
                    yi  <= c_yi[DW-1:0];
                    sat <= sat_c;
                end
            end
            if (en && s3_valid && sat_c)
                ovf_sticky <= 1'b1;
            else if (clr_ovf)
                ovf_sticky <= 1'b0;
        end
    end

endmodule

// File: tb/tb_butterfly_r2_pipe.sv
// tb_butterfly_r2_pipe
// Self-checking bench for butterfly_r2_pipe (DW=16, TW=16). Directed beats
// with known results, a backpressure stall, reset with a full pipeline and a
// randomized run, all compared against a complex-arithmetic reference model.
module tb_butterfly_r2_pipe;
    localparam int DW = 16;
    localparam int TW = 16;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 in_valid = 1'b0;
    logic                 in_ready;
    logic signed [DW-1:0] ar = '0, ai = '0, br = '0, bi = '0;
    logic signed [TW-1:0] wr = '0, wi = '0;
    logic                 mode_dif = 1'b0, inv = 1'b0, scale = 1'b0;
    logic                 out_valid;
    logic                 out_ready = 1'b1;
    logic signed [DW-1:0] xr, xi, yr, yi;
    logic                 sat;
    logic                 ovf_sticky;
    logic                 clr_ovf = 1'b0;

    butterfly_r2_pipe #(.DW(DW), .TW(TW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .ar(ar), .ai(ai), .br(br), .bi(bi),
        .wr(wr), .wi(wi),
        .mode_dif(mode_dif), .inv(inv), .scale(scale),
        .out_valid(out_valid), .out_ready(out_ready),
        .xr(xr), .xi(xi), .yr(yr), .yi(yi),
        .sat(sat), .ovf_sticky(ovf_sticky), .clr_ovf(clr_ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        int ar, ai, br, bi, wr, wi;
        bit dif, inv, scl;
    } beat_t;

    typedef struct {
        int xr, xi, yr, yi;
        bit sat;
    } res_t;

    res_t  exp_q[$];
    int    checks = 0;
    int    errors = 0;
    int    delivered = 0;
    beat_t nob = '{default: 0};

    // Reference: complex butterfly in plain integer arithmetic.
    function automatic int clampv(input longint v, inout bit s);
        longint hi = (longint'(1) << (DW-1)) - 1;
        longint lo = -(longint'(1) << (DW-1));
        if (v > hi) begin s = 1'b1; return int'(hi); end
        if (v < lo) begin s = 1'b1; return int'(lo); end
        return int'(v);
    endfunction

    function automatic res_t refModel(input beat_t b);
        res_t   r;
        bit     s = 1'b0;
        longint sg = b.inv ? -1 : 1;
        longint mr, mi, zr, zi, vxr, vxi, vyr, vyi;
        longint half = longint'(1) << (TW-2);
        mr = b.dif ? longint'(b.ar - b.br) : longint'(b.br);
        mi = b.dif ? longint'(b.ai - b.bi) : longint'(b.bi);
        zr = (mr * b.wr - sg * mi * b.wi + half) >>> (TW-1);
        zi = (sg * mr * b.wi + mi * b.wr + half) >>> (TW-1);
        if (b.dif) begin
            vxr = b.ar + b.br; vxi = b.ai + b.bi; vyr = zr; vyi = zi;
        end else begin
            vxr = b.ar + zr; vxi = b.ai + zi; vyr = b.ar - zr; vyi = b.ai - zi;
        end
        if (b.scl) begin
            vxr = (vxr + 1) >>> 1; vxi = (vxi + 1) >>> 1;
            vyr = (vyr + 1) >>> 1; vyi = (vyi + 1) >>> 1;
        end
        r.xr = clampv(vxr, s);
        r.xi = clampv(vxi, s);
        r.yr = clampv(vyr, s);
        r.yi = clampv(vyi, s);
        r.sat = s;
        return r;
    endfunction

    function automatic beat_t mkBeat(input int a_r, a_i, b_r, b_i, w_r, w_i,
                                     input bit dif, iv, sc);
        beat_t b;
        b.ar = a_r; b.ai = a_i; b.br = b_r; b.bi = b_i; b.wr = w_r; b.wi = w_i;
        b.dif = dif; b.inv = iv; b.scl = sc;
        return b;
    endfunction

    function automatic int rnd16();
        return int'($urandom_range(65535)) - 32768;
    endfunction

    function automatic beat_t randBeat();
        return mkBeat(rnd16(), rnd16(), rnd16(), rnd16(), rnd16(), rnd16(),
                      1'($urandom_range(1)), 1'($urandom_range(1)), 1'($urandom_range(1)));
    endfunction

    task automatic checkSignal(input string tag, input logic signed [31:0] obs,
                               input logic signed [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // Compare the beat leaving the DUT against the oldest expected result.
    task automatic checkOutput();
        res_t e;
        if (exp_q.size() == 0) begin
            checkSignal("unexpected_output", 32'(out_valid), 0);
            return;
        end
        e = exp_q.pop_front();
        delivered++;
        checkSignal("beat_xr", 32'(xr), e.xr);
        checkSignal("beat_xi", 32'(xi), e.xi);
        checkSignal("beat_yr", 32'(yr), e.yr);
        checkSignal("beat_yi", 32'(yi), e.yi);
        checkSignal("beat_sat", 32'(sat), 32'(e.sat));
    endtask

    task automatic applyStimulus(input bit v, input beat_t b);
        in_valid = v;
        ar = DW'(b.ar); ai = DW'(b.ai); br = DW'(b.br); bi = DW'(b.bi);
        wr = TW'(b.wr); wi = TW'(b.wi);
        mode_dif = b.dif; inv = b.inv; scale = b.scl;
    endtask

    // One clock cycle: drive after the falling edge, then observe what the
    // next rising edge will transfer.
    task automatic step(input bit v, input beat_t b, input bit ordy);
        @(negedge clk);
        applyStimulus(v, b);
        out_ready = ordy;
        #1;
        if (rst) begin
            exp_q.delete();
        end else begin
            if (in_valid && in_ready) exp_q.push_back(refModel(b));
            if (out_valid && out_ready) checkOutput();
        end
    endtask

    task automatic runOne(input string tag, input beat_t b,
                          input int exr, exi, eyr, eyi, input int esat);
        step(1'b1, b, 1'b1);
        for (int k = 0; k < 3; k++) begin
            step(1'b0, nob, 1'b1);
            checkSignal({tag, "_early_valid"}, 32'(out_valid), 0);
        end
        step(1'b0, nob, 1'b1);
        checkSignal({tag, "_valid"}, 32'(out_valid), 1);
        checkSignal({tag, "_xr"}, 32'(xr), exr);
        checkSignal({tag, "_xi"}, 32'(xi), exi);
        checkSignal({tag, "_yr"}, 32'(yr), eyr);
        checkSignal({tag, "_yi"}, 32'(yi), eyi);
        checkSignal({tag, "_sat"}, 32'(sat), esat);
    endtask

    task automatic drain();
        for (int k = 0; k < 60 && exp_q.size() != 0; k++) step(1'b0, nob, 1'b1);
        checkSignal("drain_pending", exp_q.size(), 0);
    endtask

    logic signed [DW-1:0] snap_xr, snap_xi, snap_yr, snap_yi;
    beat_t satb;
    int    base;

    initial begin
        // Reset and first cycle after release
        rst = 1'b1;
        repeat (3) step(1'b0, nob, 1'b1);
        rst = 1'b0;
        step(1'b0, nob, 1'b0);
        checkSignal("rst_out_valid", 32'(out_valid), 0);
        checkSignal("rst_in_ready", 32'(in_ready), 1);
        checkSignal("rst_ovf", 32'(ovf_sticky), 0);
        checkSignal("rst_xr", 32'(xr), 0);

        runOne("dit_fwd", mkBeat(1000, 0, 2000, 0, 0, -32768, 0, 0, 0), 1000, -2000, 1000, 2000, 0);
        runOne("dit_inv", mkBeat(1000, 0, 2000, 0, 0, -32768, 0, 1, 0), 1000, 2000, 1000, -2000, 0);

        // Saturation and sticky flag
        satb = mkBeat(32767, 0, 32767, 0, 16384, 0, 0, 0, 0);
        runOne("sat", satb, 32767, 0, 16383, 0, 1);
        checkSignal("sat_ovf_set", 32'(ovf_sticky), 1);
        repeat (3) step(1'b0, nob, 1'b1);
        checkSignal("sat_ovf_hold", 32'(ovf_sticky), 1);
        clr_ovf = 1'b1;
        step(1'b0, nob, 1'b1);
        clr_ovf = 1'b0;
        step(1'b0, nob, 1'b1);
        checkSignal("ovf_cleared", 32'(ovf_sticky), 0);

        runOne("sat_scaled", mkBeat(32767, 0, 32767, 0, 16384, 0, 0, 0, 1), 24576, 0, 8192, 0, 0);
        checkSignal("scaled_ovf", 32'(ovf_sticky), 0);

        runOne("dif", mkBeat(300, 100, 100, -100, 16384, 0, 1, 0, 0), 400, 0, 100, 100, 0);

        // clr_ovf coinciding with a saturating beat entering the output register
        step(1'b1, satb, 1'b1);
        step(1'b0, nob, 1'b1);
        step(1'b0, nob, 1'b1);
        clr_ovf = 1'b1;
        step(1'b0, nob, 1'b1);
        clr_ovf = 1'b0;
        step(1'b0, nob, 1'b1);
        checkSignal("set_wins_valid", 32'(out_valid), 1);
        checkSignal("set_wins_ovf", 32'(ovf_sticky), 1);
        clr_ovf = 1'b1;
        step(1'b0, nob, 1'b1);
        clr_ovf = 1'b0;
        drain();

        // Backpressure: four back-to-back beats, three stalled cycles
        base = delivered;
        for (int k = 0; k < 4; k++) step(1'b1, randBeat(), 1'b1);
        step(1'b0, nob, 1'b0);
        checkSignal("bp_valid", 32'(out_valid), 1);
        checkSignal("bp_in_ready", 32'(in_ready), 0);
        snap_xr = xr; snap_xi = xi; snap_yr = yr; snap_yi = yi;
        for (int k = 0; k < 2; k++) begin
            step(1'b0, nob, 1'b0);
            checkSignal("bp_stall_in_ready", 32'(in_ready), 0);
            checkSignal("bp_stall_valid", 32'(out_valid), 1);
            checkSignal("bp_stall_xr", 32'(xr), 32'(snap_xr));
            checkSignal("bp_stall_xi", 32'(xi), 32'(snap_xi));
            checkSignal("bp_stall_yr", 32'(yr), 32'(snap_yr));
            checkSignal("bp_stall_yi", 32'(yi), 32'(snap_yi));
        end
        drain();
        checkSignal("bp_delivered", delivered - base, 4);

        // Reset with a full pipeline and the sticky flag set
        runOne("pre_rst_sat", satb, 32767, 0, 16383, 0, 1);
        for (int k = 0; k < 4; k++) step(1'b1, randBeat(), 1'b1);
        checkSignal("pre_rst_ovf", 32'(ovf_sticky), 1);
        rst = 1'b1;
        clr_ovf = 1'b0;
        step(1'b0, nob, 1'b1);
        rst = 1'b0;
        step(1'b0, nob, 1'b1);
        checkSignal("mid_rst_out_valid", 32'(out_valid), 0);
        checkSignal("mid_rst_xr", 32'(xr), 0);
        checkSignal("mid_rst_xi", 32'(xi), 0);
        checkSignal("mid_rst_yr", 32'(yr), 0);
        checkSignal("mid_rst_yi", 32'(yi), 0);
        checkSignal("mid_rst_sat", 32'(sat), 0);
        checkSignal("mid_rst_ovf", 32'(ovf_sticky), 0);
        checkSignal("mid_rst_in_ready", 32'(in_ready), 1);
        for (int k = 0; k < 6; k++) begin
            step(1'b0, nob, 1'b1);
            checkSignal("post_rst_no_output", 32'(out_valid), 0);
        end

        // Randomized traffic with random backpressure and mixed modes
        for (int k = 0; k < 400; k++)
            step($urandom_range(3) != 0, randBeat(), $urandom_range(3) != 0);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
